// File: rtl/aes_192_ctr_seq.sv
// Upstream sequencer for the serialized AES-192 CTR core: owns the counter block, launches one
// core run per accepted input block and returns the core's XORed result over valid/ready.
module aes_192_ctr_seq #(
    parameter int CTR_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [191:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err_timeout,
    output logic         ctr_wrap,
    output logic         core_start,
    output logic [127:0] core_state,
    output logic [127:0] core_text,
    output logic [191:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_out_valid
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [191:0]       key_reg;
    logic [127:0]       ctr_reg;
    logic [127:0]       ctr_inc;
    logic [TMR_W-1:0]   timer_reg;
    logic               done_prev_reg;
    logic [127:0]       out_data_reg;
    logic [127:0]       core_state_reg;
    logic [127:0]       core_text_reg;
    logic [191:0]       core_key_reg;
    logic               err_timeout_reg;
    logic               ctr_wrap_reg;

    logic               accept;
    logic               capture;
    logic               abort;
    logic               done;
    logic               tmr_expire;

    logic [CTR_W-1:0]   ctr_low;
    logic [CTR_W-1:0]   ctr_low_inc;
    logic               ctr_low_max;

    // Only the low CTR_W field counts; anything above it is carried through untouched.
    assign ctr_low     = ctr_reg[CTR_W-1:0];
    assign ctr_low_inc = ctr_low + CTR_W'(1);
    assign ctr_low_max = &ctr_low;

    generate
        if (CTR_W < 128) begin : g_upper
            assign ctr_inc = {ctr_reg[127:CTR_W], ctr_low_inc};
        end else begin : g_full
            assign ctr_inc = ctr_low_inc;
        end
    endgenerate

    // Only a fresh 0->1 edge counts as done, so a level held over from the last block is ignored.
    assign done = core_out_valid && !done_prev_reg;

    // The current RUN cycle is cycle number timer_reg+1; expire on the TIMEOUT-th one.
    assign tmr_expire = (timer_reg == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!load && in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (done) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end else if (tmr_expire) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            key_reg         <= '0;
            ctr_reg         <= '0;
            timer_reg       <= '0;
            out_data_reg    <= '0;
            core_state_reg  <= '0;
            core_text_reg   <= '0;
            core_key_reg    <= '0;
            err_timeout_reg <= 1'b0;
            ctr_wrap_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && load) begin
                key_reg      <= key;
                ctr_reg      <= iv;
                ctr_wrap_reg <= 1'b0;
            end
            if (accept) begin
                core_state_reg <= ctr_reg;
                core_text_reg  <= in_data;
                core_key_reg   <= key_reg;
                timer_reg      <= '0;
            end
            if (state_reg == RUN) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
            if (capture) begin
                out_data_reg <= core_out;
                ctr_reg      <= ctr_inc;
                if (ctr_low_max) begin
                    ctr_wrap_reg <= 1'b1;
                end
            end
            if (abort) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    // Tracks the core even through reset so a level held across reset is not mistaken for done.
    always_ff @(posedge clk) begin
        done_prev_reg <= core_out_valid;
    end

    assign in_ready    = !rst && (state_reg == IDLE) && !load;
    assign out_valid   = (state_reg == OUT);
    assign out_data    = out_data_reg;
    assign busy        = (state_reg != IDLE);
    assign err_timeout = err_timeout_reg;
    assign ctr_wrap    = ctr_wrap_reg;
    assign core_start  = (state_reg == RUN);
    assign core_state  = core_state_reg;
    assign core_text   = core_text_reg;
    assign core_key    = core_key_reg;

endmodule

// File: tb/tb_aes_192_ctr_seq.sv
// Bench for aes_192_ctr_seq: a behavioural AES-192 core model drives the core side, and a
// counter/key/queue reference model checks every result block, core launch and flag.
module tb_aes_192_ctr_seq;

    localparam int CTR_W    = 32;
    localparam int TIMEOUT  = 8;
    localparam int M_NORMAL = 0;
    localparam int M_STALE  = 1;
    localparam int M_NEVER  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [191:0] key;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         err_timeout;
    logic         ctr_wrap;
    logic         core_start;
    logic [127:0] core_state;
    logic [127:0] core_text;
    logic [191:0] core_key;
    logic [127:0] core_out;
    logic         core_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int core_mode = M_NORMAL;
    int core_lat  = 3;

    // reference model state
    logic [191:0] key_m  = '0;
    logic [127:0] ctr_m  = '0;
    logic         wrap_m = 1'b0;
    logic         err_m  = 1'b0;
    logic [127:0] exp_q[$];

    logic [7:0] sbox [256];

    always #5 clk = ~clk;

    aes_192_ctr_seq #(.CTR_W(CTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout), .ctr_wrap(ctr_wrap),
        .core_start(core_start), .core_state(core_state), .core_text(core_text),
        .core_key(core_key), .core_out(core_out), .core_out_valid(core_out_valid)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk192(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES-192 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    initial begin
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            sbox[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes192(input logic [191:0] k, input logic [127:0] pt);
        logic [31:0]  w [52];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            tmp = w[i-1];
            if (i % 6 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-6] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 12; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int rr = 0; rr < 4; rr++)
                        s[rr+4*c] = t[rr+4*((c+rr)%4)];
                if (r < 12) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
                        s[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = s[rr+4*c] ^ w[4*r+c][31-8*rr -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- core model ----------------
    initial begin
        logic         start_prev;
        int           cnt;
        logic [127:0] res;
        start_prev     = 1'b0;
        cnt            = 0;
        res            = '0;
        core_out       = '0;
        core_out_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                core_out_valid = 1'b0;
                cnt            = 0;
                start_prev     = 1'b0;
            end else begin
                if (core_start && !start_prev) begin
                    res = core_text ^ aes192(core_key, core_state);
                    cnt = core_lat;
                    if (core_mode == M_STALE) core_out = rand128();
                    else core_out_valid = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 1 && core_mode == M_STALE) core_out_valid = 1'b0;
                    if (cnt == 0 && core_mode != M_NEVER) begin
                        core_out_valid = 1'b1;
                        core_out       = res;
                    end
                end
                if (!core_start && core_mode != M_STALE) core_out_valid = 1'b0;
                start_prev = core_start;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin
        logic         cov_last;
        logic         exp_start_next, exp_ov_next, exp_to_next;
        int           run_cnt;
        int           blk;
        logic [127:0] e_state, e_text, e_out;
        logic [191:0] e_key;
        logic [31:0]  lo;
        cov_last = 1'b0; exp_start_next = 1'b0; exp_ov_next = 1'b0; exp_to_next = 1'b0;
        run_cnt = 0; blk = 0; e_state = '0; e_text = '0; e_key = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                key_m = '0; ctr_m = '0; wrap_m = 1'b0; err_m = 1'b0;
                exp_start_next = 1'b0; exp_ov_next = 1'b0; exp_to_next = 1'b0;
                run_cnt = 0;
            end else begin
                if (exp_start_next) begin
                    chk1("start_after_accept", core_start, 1'b1);
                    chk128("core_state", core_state, e_state);
                    chk128("core_text", core_text, e_text);
                    chk192("core_key", core_key, e_key);
                end
                if (exp_ov_next) chk1("out_valid_after_done", out_valid, 1'b1);
                if (exp_to_next) begin
                    chk1("timeout_idle", busy, 1'b0);
                    chk1("timeout_flag", err_timeout, 1'b1);
                    chk1("timeout_no_out", out_valid, 1'b0);
                end
                exp_start_next = 1'b0; exp_ov_next = 1'b0; exp_to_next = 1'b0;
                chk1("in_ready", in_ready, !busy && !load);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk1("unexpected_out_valid", out_valid, 1'b0);
                    end else if (out_ready) begin
                        e_out = exp_q.pop_front();
                        chk128("out_data", out_data, e_out);
                        $display("block %0d: out_data=%h", blk, out_data);
                        blk++;
                    end
                end
                if (core_start) begin
                    run_cnt++;
                    if (core_out_valid && !cov_last) exp_ov_next = 1'b1;
                    else if (run_cnt == TIMEOUT) exp_to_next = 1'b1;
                end else begin
                    run_cnt = 0;
                end
                if (load && !busy) begin
                    key_m = key; ctr_m = iv; wrap_m = 1'b0;
                end else if (in_valid && in_ready) begin
                    chk1("start_low_at_accept", core_start, 1'b0);
                    e_state = ctr_m; e_text = in_data; e_key = key_m;
                    exp_start_next = 1'b1;
                    if (core_mode == M_NEVER) begin
                        err_m = 1'b1;
                    end else begin
                        exp_q.push_back(in_data ^ aes192(key_m, ctr_m));
                        lo = ctr_m[31:0] + 32'd1;
                        if (lo == 32'd0) wrap_m = 1'b1;
                        ctr_m[31:0] = lo;
                    end
                end
            end
            cov_last = core_out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_load(input logic [191:0] k, input logic [127:0] v);
        @(posedge clk); #1;
        load = 1'b1; key = k; iv = v;
        @(posedge clk); #1;
        load = 1'b0; key = rand128(); iv = rand128();
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) chk1("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rand128();
    endtask

    task automatic drain(input bit rnd_ready);
        int n;
        n = 0;
        while (busy && n < 300) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk1("drain_timeout", busy, 1'b0);
        chk1("err_timeout", err_timeout, err_m);
        chk1("ctr_wrap", ctr_wrap, wrap_m);
    endtask

    initial begin
        logic [127:0] held;
        int           n;
        rst = 1'b1; load = 1'b0; key = '0; iv = '0;
        in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;

        // reset with in_valid held high
        repeat (3) begin
            @(negedge clk);
            chk1("rst_in_ready", in_ready, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_core_start", core_start, 1'b0);
            chk1("rst_err_timeout", err_timeout, 1'b0);
            chk1("rst_ctr_wrap", ctr_wrap, 1'b0);
            chk128("rst_out_data", out_data, 128'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;

        // FIPS-197 AES-192 vector through CTR with zero text
        core_mode = M_NORMAL; core_lat = 4;
        do_load(192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                128'h00112233445566778899aabbccddeeff);
        send(128'h0);
        drain(1'b0);
        chk128("fips_out_data", out_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        send(rand128());
        chk128("fips_next_ctr", core_state, 128'h00112233445566778899aabbccddef00);
        drain(1'b1);

        // low-field wrap
        do_load({rand128(), $urandom(), $urandom()}, 128'h0123456789abcdef_deadbeef_ffffffff);
        send(rand128());
        drain(1'b1);
        chk1("wrap_flag", ctr_wrap, 1'b1);
        send(rand128());
        chk128("wrap_next_ctr", core_state, 128'h0123456789abcdef_deadbeef_00000000);
        drain(1'b1);

        // stale done level held between blocks
        core_mode = M_STALE;
        for (int i = 0; i < 4; i++) begin
            core_lat = $urandom_range(2, 7);
            send(rand128());
            drain(1'b1);
        end

        // timeout: core never completes
        core_mode = M_NEVER; core_lat = 3;
        do_load({rand128(), $urandom(), $urandom()}, 128'hfeedface_00000000_11111111_00000005);
        send(rand128());
        drain(1'b1);
        chk1("timeout_sticky", err_timeout, 1'b1);
        core_mode = M_NORMAL;
        send(rand128());
        chk128("timeout_ctr_unchanged", core_state, 128'hfeedface_00000000_11111111_00000005);
        drain(1'b1);

        // done arriving in the last allowed RUN cycle wins over expiry
        core_lat = TIMEOUT - 1;
        send(rand128());
        drain(1'b1);

        // backpressure with load ignored, then load + in_valid together in IDLE
        core_lat = 3;
        out_ready = 1'b0;
        send(rand128());
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk1("bp_out_valid", out_valid, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            load = i[0]; key = {rand128(), $urandom(), $urandom()}; iv = rand128();
            @(negedge clk);
            chk128("bp_out_data_stable", out_data, held);
            chk1("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        load = 1'b0;
        drain(1'b0);
        load = 1'b1; in_valid = 1'b1; in_data = rand128();
        key = 192'h55555555_66666666_77777777_88888888_99999999_aaaaaaaa;
        iv  = 128'h0badcafe_12345678_9abcdef0_00000010;
        @(negedge clk);
        chk1("load_wins_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        load = 1'b0; key = rand128(); iv = rand128();
        @(negedge clk);
        chk1("accept_after_load", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk128("load_iv_used", core_state, 128'h0badcafe_12345678_9abcdef0_00000010);
        chk192("load_key_used", core_key, 192'h55555555_66666666_77777777_88888888_99999999_aaaaaaaa);
        drain(1'b1);

        // reset in the middle of a block
        core_lat = 6;
        send(rand128());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_core_start", core_start, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_err_cleared", err_timeout, 1'b0);
        chk128("midrst_core_state", core_state, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // randomized blocks
        do_load({rand128(), $urandom(), $urandom()}, rand128());
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            core_mode = (n == 0) ? M_NEVER : (n < 4) ? M_STALE : M_NORMAL;
            core_lat  = $urandom_range(2, 7);
            if ($urandom_range(0, 4) == 0) begin
                held = rand128();
                case ($urandom_range(0, 2))
                    0: held[31:0] = 32'hffffffff;
                    1: held[31:0] = 32'hfffffffe;
                    default: ;
                endcase
                do_load({rand128(), $urandom(), $urandom()}, held);
            end
            send(rand128());
            drain(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
